// File: rtl/fifo_disp_pkg.sv
// Shared types and helpers for the FIFO read-side pop/display controller.
package fifo_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SSD_BLANK  = 7'h7F;

    // Segment order gfedcba, active-low.
    function automatic logic [6:0] hex_to_ssd(input logic [3:0] i_val);
        logic [6:0] w_seg;
        case (i_val)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, level debounce and rising-edge press pulse for a raw push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int              CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync0   <= i_btn;
            r_sync1   <= r_sync0;
            r_level_d <= r_level;
            if (r_sync1 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/fifo_pop_display.sv
// FIFO read-side controller: one read strobe per debounced press, 8-deep pop history on the SSD.
// ST_IDLE | wait for press | ST_POP | rd strobe | ST_CAPTURE | latch read data into history
module fifo_pop_display
    import fifo_disp_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SCAN_DIV     = 100_000
) (
    input  logic              fifo_pop_display_port_clk,
    input  logic              fifo_pop_display_port_rst,
    input  logic              fifo_pop_display_port_btn_r,
    input  logic              fifo_pop_display_port_empty,
    input  logic [DATA_W-1:0] fifo_pop_display_port_data,
    output logic              fifo_pop_display_port_rd,
    output logic              fifo_pop_display_port_underflow,
    output logic [7:0]        fifo_pop_display_port_count,
    output logic [7:0]        fifo_pop_display_port_an,
    output logic [6:0]        fifo_pop_display_port_ssd
);

    localparam int               SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic                  w_clk;
    logic                  w_rst;
    logic                  w_press;
    logic                  w_rd;
    logic                  w_capture;
    logic                  w_underflow_set;
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_underflow;
    logic [7:0]            r_count;
    logic [3:0]            r_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_valid;
    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [2:0]            r_idx;
    logic [7:0]            r_an;
    logic [6:0]            r_ssd;

    assign w_clk = fifo_pop_display_port_clk;
    assign w_rst = fifo_pop_display_port_rst;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
        .i_clk  (w_clk),
        .i_rst  (w_rst),
        .i_btn  (fifo_pop_display_port_btn_r),
        .o_press(w_press)
    );

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Presses seen outside IDLE are intentionally dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_press && !fifo_pop_display_port_empty) begin
                    w_state_nxt = ST_POP;
                end
            end
            ST_POP:     w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd            = (r_state == ST_POP);
        w_capture       = (r_state == ST_CAPTURE);
        w_underflow_set = (r_state == ST_IDLE) && w_press && fifo_pop_display_port_empty;
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_underflow <= 1'b0;
            r_count     <= 8'd0;
            r_valid     <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= 4'd0;
            end
        end else begin
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end
            if (w_capture) begin
                r_count <= r_count + 8'd1;
                r_valid <= {r_valid[NUM_DIGITS-2:0], 1'b1};
                for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                    r_digit[i] <= r_digit[i-1];
                end
                r_digit[0] <= fifo_pop_display_port_data[3:0];
            end
        end
    end

    // an/ssd are both registered from the same index so they switch on the same edge.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
            r_an       <= 8'b1111_1110;
            r_ssd      <= SSD_BLANK;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            r_an  <= ~(8'b1 << r_idx);
            r_ssd <= r_valid[r_idx] ? hex_to_ssd(r_digit[r_idx]) : SSD_BLANK;
        end
    end

    assign fifo_pop_display_port_rd        = w_rd;
    assign fifo_pop_display_port_underflow = r_underflow;
    assign fifo_pop_display_port_count     = r_count;
    assign fifo_pop_display_port_an        = r_an;
    assign fifo_pop_display_port_ssd       = r_ssd;

endmodule

// File: tb/tb_fifo_pop_display.sv
// Self-checking bench for fifo_pop_display: behavioural model compared every cycle plus directed literal checks.
module tb_fifo_pop_display;

    localparam int DEB  = 4;
    localparam int SCAN = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       btn   = 1'b0;
    logic       empty = 1'b1;
    logic [3:0] data  = 4'd0;
    logic       rd;
    logic       under;
    logic [7:0] count;
    logic [7:0] an;
    logic [6:0] ssd;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    // Behavioural model state: history as ints (-1 = empty slot), pop phase, debounce run length.
    int         m_hist [8];
    int         m_phase;
    int         m_run;
    int         m_n;
    int         m_count;
    bit         m_under;
    bit         m_level;
    bit         m_prev;
    bit         m_s0;
    bit         m_s1;
    bit         m_ok = 1'b0;
    logic [7:0] m_an;
    logic [6:0] m_ssd;

    fifo_pop_display #(
        .DATA_W      (4),
        .DEBOUNCE_CYC(DEB),
        .SCAN_DIV    (SCAN)
    ) dut (
        .fifo_pop_display_port_clk      (clk),
        .fifo_pop_display_port_rst      (rst),
        .fifo_pop_display_port_btn_r    (btn),
        .fifo_pop_display_port_empty    (empty),
        .fifo_pop_display_port_data     (data),
        .fifo_pop_display_port_rd       (rd),
        .fifo_pop_display_port_underflow(under),
        .fifo_pop_display_port_count    (count),
        .fifo_pop_display_port_an       (an),
        .fifo_pop_display_port_ssd      (ssd)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int v);
        case (v & 15)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin : model
        int idx;
        bit press;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_hist[i] = -1;
            m_phase = 0; m_run = 0; m_n = 0; m_count = 0;
            m_under = 0; m_level = 0; m_prev = 0; m_s0 = 0; m_s1 = 0;
            m_an = 8'hFE; m_ssd = 7'h7F; m_ok = 1'b1;
        end else begin
            idx   = (m_n / SCAN) % 8;
            m_an  = ~(8'd1 << idx);
            m_ssd = (m_hist[idx] < 0) ? 7'h7F : seg(m_hist[idx]);
            m_n++;
            press = m_level && !m_prev;
            case (m_phase)
                0: if (press) begin
                       if (empty) m_under = 1;
                       else       m_phase = 1;
                   end
                1: m_phase = 2;
                default: begin
                    for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
                    m_hist[0] = int'(data);
                    m_count   = (m_count + 1) % 256;
                    m_phase   = 0;
                end
            endcase
            m_prev = m_level;
            if (m_s1 != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = m_s1;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s1 = m_s0;
            m_s0 = btn;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("cyc_rd",    32'(rd),    32'(m_phase == 1));
            check("cyc_under", 32'(under), 32'(m_under));
            check("cyc_count", 32'(count), 32'(m_count));
            check("cyc_an",    32'(an),    32'(m_an));
            check("cyc_ssd",   32'(ssd),   32'(m_ssd));
            if (rd === 1'b1) pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 1'b0;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic press_btn(input int hi);
        btn = 1'b1;
        tick(hi);
        btn = 1'b0;
        tick(12);
    endtask

    task automatic count_nonblank(input int n, output int nb);
        nb = 0;
        for (int c = 0; c < n; c++) begin
            tick(1);
            if (ssd !== 7'h7F) nb++;
        end
    endtask

    initial begin
        int nb;
        int seen;
        int badrot;
        int trans;
        int w;
        logic [7:0] prev_an;

        // Reset only
        do_reset();
        check("rst_an",    32'(an),    32'h0FE);
        check("rst_ssd",   32'(ssd),   32'h07F);
        check("rst_rd",    32'(rd),    32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_under", 32'(under), 32'd0);
        count_nonblank(32, nb);
        check("rst_blank_scan", 32'(nb), 32'd0);

        // Single pop of value 4
        empty  = 1'b0;
        data   = 4'd4;
        pulses = 0;
        press_btn(10);
        check("pop1_pulses", 32'(pulses), 32'd1);
        check("pop1_count",  32'(count),  32'd1);
        nb = 0; seen = 0;
        for (int c = 0; c < 32; c++) begin
            tick(1);
            if (an === 8'hFE) begin
                seen++;
                if (ssd !== 7'b0011001) nb++;
            end else if (ssd !== 7'h7F) begin
                nb++;
            end
        end
        check("pop1_digits",  32'(nb),   32'd0);
        check("pop1_fe_seen", 32'(seen), 32'd4);

        // Bouncing button, then a stable hold
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            btn = 1'b1; tick(2);
            btn = 1'b0; tick(2);
        end
        check("bounce_no_pulse", 32'(pulses), 32'd0);
        press_btn(10);
        check("bounce_pulses", 32'(pulses), 32'd1);
        check("bounce_count",  32'(count),  32'd2);

        // Underflow is sticky and blocks rd only while empty
        empty  = 1'b1;
        pulses = 0;
        press_btn(10);
        check("uf_no_rd", 32'(pulses), 32'd0);
        check("uf_flag",  32'(under),  32'd1);
        check("uf_count", 32'(count),  32'd2);
        empty  = 1'b0;
        data   = 4'hA;
        pulses = 0;
        press_btn(10);
        check("uf_then_pop_rd", 32'(pulses), 32'd1);
        check("uf_sticky",      32'(under),  32'd1);
        check("uf_count2",      32'(count),  32'd3);

        // History wrap: nine pops of 0..8
        do_reset();
        empty = 1'b0;
        for (int i = 0; i < 9; i++) begin
            data = 4'(i);
            press_btn(10);
        end
        check("wrap_count", 32'(count),     32'd9);
        check("model_h0",   32'(m_hist[0]), 32'd8);
        check("model_h7",   32'(m_hist[7]), 32'd1);
        nb = 0; badrot = 0; trans = 0;
        prev_an = an;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            if (an !== prev_an) begin
                trans++;
                if (an !== {prev_an[6:0], prev_an[7]}) badrot++;
            end
            prev_an = an;
            seen = -1;
            for (int i = 0; i < 8; i++) if (an === ~(8'd1 << i)) seen = i;
            if (seen < 0 || ssd !== seg(8 - seen)) nb++;
        end
        check("wrap_digits", 32'(nb),         32'd0);
        check("wrap_an_rot", 32'(badrot),     32'd0);
        check("wrap_an_cnt", 32'(trans >= 8), 32'd1);

        // Reset landing in the POP cycle
        data  = 4'd5;
        empty = 1'b0;
        btn   = 1'b1;
        w = 0;
        while (rd !== 1'b1 && w < 40) begin
            tick(1);
            w++;
        end
        check("midrst_reach_pop", 32'(rd), 32'd1);
        rst = 1'b1;
        btn = 1'b0;
        tick(1);
        check("midrst_rd",    32'(rd),    32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_an",    32'(an),    32'h0FE);
        check("midrst_ssd",   32'(ssd),   32'h07F);
        rst = 1'b0;
        count_nonblank(32, nb);
        check("midrst_blank",  32'(nb),    32'd0);
        check("midrst_count2", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
